// File: rtl/aes_mask_pkg.sv
// Shared definitions for the AES mask engine: GF(2^8) helpers,
// the MixColumns transform, FSM encoding and counter width.
package aes_mask_pkg;

    localparam int CTR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } fsm_t;

    // Multiply by 2 in GF(2^8), reduction polynomial 0x11b
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by 3 in GF(2^8)
    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    // MixColumns on one 32-bit column, byte 0 in bits [31:24]
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm2(a0) ^ gm3(a1) ^ a2      ^ a3,
                a0      ^ gm2(a1) ^ gm3(a2) ^ a3,
                a0      ^ a1      ^ gm2(a2) ^ gm3(a3),
                gm3(a0) ^ a1      ^ a2      ^ gm2(a3)};
    endfunction

    // MixColumns on the full state, column 0 in bits [127:96]
    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
    endfunction

endpackage

// File: rtl/aes_mask_keysched.sv
// Round-key schedule for the mask engine: holds the working key and a
// shadow copy of the key latched at start, rotates per round according
// to the latched key-length mode, and folds the shadow back in on finalize.
module aes_mask_keysched
    import aes_mask_pkg::*;
#(
    parameter int ROT128 = 19,
    parameter int ROT256 = 22
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         step,
    input  logic         finalize,
    input  logic         clear,
    input  logic         keylen,
    input  logic [255:0] key,
    output logic [127:0] rk
);

    logic [255:0] key_reg;
    logic [255:0] shadow_reg;
    logic         keylen_reg;
    logic [255:0] key_load;
    logic [255:0] key_rot;

    // In 128-bit mode only the upper half is meaningful; lower half stays zero
    assign key_load = keylen ? key : {key[255:128], 128'h0};

    // Mode-dependent right rotation of the working key
    always_comb begin
        key_rot = '0;
        if (keylen_reg) begin
            key_rot = (key_reg >> ROT256) | (key_reg << (256 - ROT256));
        end else begin
            key_rot[255:128] = (key_reg[255:128] >> ROT128)
                             | (key_reg[255:128] << (128 - ROT128));
        end
    end

    // Working key, shadow key and mode registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_reg    <= '0;
            shadow_reg <= '0;
            keylen_reg <= 1'b0;
        end else if (clear) begin
            key_reg    <= '0;
            shadow_reg <= '0;
            keylen_reg <= 1'b0;
        end else if (load) begin
            key_reg    <= key_load;
            shadow_reg <= key_load;
            keylen_reg <= keylen;
        end else if (step) begin
            key_reg <= key_rot;
        end else if (finalize) begin
            key_reg <= key_rot ^ shadow_reg;
        end
    end

    assign rk = key_reg[255:128];

endmodule

// File: rtl/aes_mask_engine.sv
// Self-sequencing AES mask engine: on start it runs ROUNDS cycles of
// MixColumns + round-key XOR, then one finalize cycle, and holds a
// valid-qualified result until the next accepted start or clear.
module aes_mask_engine
    import aes_mask_pkg::*;
#(
    parameter int ROUNDS = 10,
    parameter int ROT128 = 19,
    parameter int ROT256 = 22
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         clear,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [127:0] block,
    output logic         ready,
    output logic         valid,
    output logic [127:0] result
);

    localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(ROUNDS - 1);

    fsm_t             fsm_reg;
    logic [127:0]     state_reg;
    logic [127:0]     block_reg;
    logic [CTR_W-1:0] ctr_reg;
    logic             valid_reg;
    logic [127:0]     rk;
    logic             ks_load;

    // A start is taken only from IDLE and only when no clear competes with it
    assign ks_load = (fsm_reg == IDLE) && start && !clear;

    aes_mask_keysched #(
        .ROT128 (ROT128),
        .ROT256 (ROT256)
    ) u_keysched (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ks_load),
        .step     (fsm_reg == ROUND),
        .finalize (fsm_reg == FINAL),
        .clear    (clear),
        .keylen   (keylen),
        .key      (key),
        .rk       (rk)
    );

    // Sequencer, round counter, state and seed-block registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            block_reg <= '0;
            ctr_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            block_reg <= '0;
            ctr_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= block;
                        block_reg <= block;
                        ctr_reg   <= '0;
                        valid_reg <= 1'b0;
                        fsm_reg   <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= mixcolumns(state_reg) ^ rk;
                    ctr_reg   <= ctr_reg + 1'b1;
                    if (ctr_reg == LAST_CTR) begin
                        fsm_reg <= FINAL;
                    end
                end
                FINAL: begin
                    state_reg <= state_reg ^ block_reg ^ rk;
                    valid_reg <= 1'b1;
                    fsm_reg   <= IDLE;
                end
                default: begin
                    fsm_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready  = (fsm_reg == IDLE);
    assign valid  = valid_reg;
    assign result = state_reg;

endmodule

// File: tb/tb_aes_mask_engine.sv
// Scoreboard bench for aes_mask_engine: one instance with ROUNDS=1 and
// one with the default ROUNDS=10; expected results are queued on each
// accepted start and checked by a monitor on every rising valid.
module tb_aes_mask_engine;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start_s  [2];
    logic         clear_s  [2];
    logic         keylen_s [2];
    logic [255:0] key_s    [2];
    logic [127:0] block_s  [2];
    logic         ready_s  [2];
    logic         valid_s  [2];
    logic [127:0] result_s [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int           inst;
        logic [127:0] res;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    logic vprev[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_mask_engine #(.ROUNDS(1)) u_r1 (
        .clk(clk), .reset_n(reset_n), .start(start_s[0]), .clear(clear_s[0]),
        .keylen(keylen_s[0]), .key(key_s[0]), .block(block_s[0]),
        .ready(ready_s[0]), .valid(valid_s[0]), .result(result_s[0])
    );

    aes_mask_engine u_r10 (
        .clk(clk), .reset_n(reset_n), .start(start_s[1]), .clear(clear_s[1]),
        .keylen(keylen_s[1]), .key(key_s[1]), .block(block_s[1]),
        .ready(ready_s[1]), .valid(valid_s[1]), .result(result_s[1])
    );

    // ---------------- reference model ----------------
    function automatic int rounds_of(input int i);
        return (i == 0) ? 1 : 10;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        logic [7:0] sh;
        sh = b << 1;
        return b[7] ? (sh ^ 8'h1b) : sh;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] s);
        logic [7:0]   a [4];
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
            for (int j = 0; j < 4; j++)
                r[127-32*c-8*j -: 8] = xt(a[j]) ^ xt(a[(j+1)%4]) ^ a[(j+1)%4]
                                     ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
        return r;
    endfunction

    // Right rotate: result bit i takes source bit i+n
    function automatic logic [255:0] m_rot(input logic [255:0] k, input logic kl);
        logic [255:0] y;
        y = '0;
        if (kl) begin
            for (int i = 0; i < 256; i++) y[i] = k[(i + 22) % 256];
        end else begin
            for (int i = 0; i < 128; i++) y[128+i] = k[128 + (i + 19) % 128];
        end
        return y;
    endfunction

    function automatic logic [127:0] m_mask(input logic [127:0] b, input logic [255:0] k0,
                                            input logic kl, input int r);
        logic [127:0] s;
        logic [255:0] k;
        s = b;
        k = kl ? k0 : {k0[255:128], 128'h0};
        for (int j = 0; j < r; j++) begin
            s = m_mix(s) ^ k[255:128];
            k = m_rot(k, kl);
        end
        return s ^ b ^ k[255:128];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Monitor: pop and compare on each rising valid; flag missed deadlines
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (valid_s[i] === 1'b1 && vprev[i] !== 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_valid inst%0d: got result %h at cyc %0d, required no valid",
                             i, result_s[i], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != i || result_s[i] !== e.res || cyc != e.due) begin
                        fails++;
                        $display("[TB] FAIL result inst%0d: got %h at cyc %0d, required inst%0d %h at cyc %0d",
                                 i, result_s[i], cyc, e.inst, e.res, e.due);
                    end else begin
                        $display("[TB] txn inst%0d result %h at cyc %0d ok", i, result_s[i], cyc);
                    end
                end
            end
            vprev[i] = valid_s[i];
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout inst%0d: got no valid by cyc %0d, required valid at cyc %0d",
                     exp_q[0].inst, cyc, exp_q[0].due);
            void'(exp_q.pop_front());
        end
    end

    // Issue one start (optionally with clear) from a negedge; queue the
    // expected result if the DUT is idle and no clear competes.
    // push: 0 = nothing queued, 1 = model value, 2 = hand value hv.
    task automatic do_start(input int i, input logic [127:0] b, input logic [255:0] k,
                            input logic kl, input logic cl, input int push,
                            input logic [127:0] hv);
        exp_t e;
        if (ready_s[i] && !cl && push != 0) begin
            e.inst = i;
            e.res  = (push == 2) ? hv : m_mask(b, k, kl, rounds_of(i));
            e.due  = cyc + rounds_of(i) + 2;
            exp_q.push_back(e);
        end
        block_s[i]  = b;
        key_s[i]    = k;
        keylen_s[i] = kl;
        clear_s[i]  = cl;
        start_s[i]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[i] = 1'b0;
        clear_s[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int lim);
        int k;
        k = 0;
        while (valid_s[i] !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("wait_valid_inst%0d", i), 128'(valid_s[i]), 128'd1);
    endtask

    task automatic chk_idle_zero(input int i, input string tag);
        chk({tag, "_result"}, result_s[i], 128'h0);
        chk({tag, "_valid"},  128'(valid_s[i]), 128'd0);
        chk({tag, "_ready"},  128'(ready_s[i]), 128'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 0; clear_s[i] = 0; keylen_s[i] = 0;
            key_s[i] = '0; block_s[i] = '0; vprev[i] = 0;
        end

        // Reset state
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk_idle_zero(0, "reset_r1");
        chk_idle_zero(1, "reset_r10");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ROUNDS=1, all-01 block, zero key: result 0 three cycles after start
        do_start(0, {16{8'h01}}, 256'h0, 1'b0, 1'b0, 2, 128'h0);
        chk("r1_busy_round", 128'(ready_s[0]), 128'd0);
        @(negedge clk);
        chk("r1_busy_final", 128'(ready_s[0]), 128'd0);
        @(negedge clk);
        chk("r1_ready_back", 128'(ready_s[0]), 128'd1);

        // Start in the first valid cycle; single-bit key shows rotation by 19
        do_start(0, 128'h0, {128'h1, 128'h0}, 1'b0, 1'b0, 2,
                 128'h0000_2000_0000_0000_0000_0000_0000_0001);
        chk("r1_valid_drop", 128'(valid_s[0]), 128'd0);
        wait_valid(0, 10);

        // ROUNDS=10, keylen=0, with ignored start pulses while busy
        do_start(1, 128'h00112233_44556677_8899aabb_ccddeeff,
                 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f,
                 1'b0, 1'b0, 1, 128'h0);
        @(negedge clk);
        do_start(1, 128'hdeadbeef_deadbeef_deadbeef_deadbeef, {8{32'hcafef00d}}, 1'b1, 1'b0, 1, 128'h0);
        @(negedge clk);
        do_start(1, 128'h5555aaaa_5555aaaa_5555aaaa_5555aaaa, {8{32'h12345678}}, 1'b0, 1'b0, 1, 128'h0);
        wait_valid(1, 20);

        // Back-to-back with keylen=1
        do_start(1, 128'h3243f6a8_885a308d_313198a2_e0370734,
                 256'h2b7e1516_28aed2a6_abf71588_09cf4f3c_603deb10_15ca71be_2b73aef0_857d7781,
                 1'b1, 1'b0, 1, 128'h0);
        chk("r10_valid_drop", 128'(valid_s[1]), 128'd0);
        wait_valid(1, 20);

        // Asynchronous reset in the fourth round cycle aborts the operation
        do_start(1, 128'hfedcba98_76543210_0f1e2d3c_4b5a6978, {8{32'ha5a5_5a5a}}, 1'b1, 1'b0, 0, 128'h0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_idle_zero(1, "async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(1, 128'hffeeddcc_bbaa9988_77665544_33221100,
                 256'h0f0e0d0c_0b0a0908_07060504_03020100_f0e0d0c0_b0a09080_70605040_30201000,
                 1'b1, 1'b0, 1, 128'h0);
        wait_valid(1, 20);

        // clear together with start in IDLE: clear wins
        do_start(1, 128'h11111111_22222222_33333333_44444444, {8{32'h9abcdef0}}, 1'b0, 1'b1, 1, 128'h0);
        chk_idle_zero(1, "clear_with_start");

        // clear during FINAL on the one-round instance
        do_start(0, 128'h01234567_89abcdef_01234567_89abcdef, {8{32'h0badf00d}}, 1'b0, 1'b0, 0, 128'h0);
        chk("r1_pre_clear_busy", 128'(ready_s[0]), 128'd0);
        @(negedge clk);
        clear_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_s[0] = 1'b0;
        chk_idle_zero(0, "clear_in_final");

        repeat (15) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the run never reaches its summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
